// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: lock-mode encodings and
// the index-width helper used to size grant indices.
package arb_pkg;

    localparam int ARB_MODE_RR   = 0;
    localparam int ARB_MODE_LOCK = 1;

    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width++;
            rem = rem >> 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/fixed_prio_encoder.sv
// Lowest-index-first priority encoder: reports whether any bit of vec is set
// and the binary index of the lowest set bit.
module fixed_prio_encoder
    import arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = clog2(N)
) (
    input  logic [N-1:0]    vec,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter with registered one-hot grant, optional grant
// locking while the winner keeps requesting, and enable gating.
module round_robin_arbiter
    import arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = 3,
    parameter int LOCK = ARB_MODE_RR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid
);

    if (IDXW != clog2(N)) begin : g_bad_idxw
        $error("round_robin_arbiter: IDXW must equal clog2(N)");
    end
    if (N < 2 || N > 32) begin : g_bad_n
        $error("round_robin_arbiter: N must be in 2..32");
    end

    logic [IDXW-1:0] ptr;
    logic [N-1:0]    above_ptr;
    logic [N-1:0]    req_masked;
    logic            found_masked;
    logic            found_any;
    logic [IDXW-1:0] idx_masked;
    logic [IDXW-1:0] idx_any;
    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic [N-1:0]    win_onehot;
    logic            hold;

    // Requesters strictly after the last winner get first chance; the
    // unmasked search provides the wrap-around back to index 0.
    always_comb begin
        above_ptr = '0;
        for (int i = 0; i < N; i++) begin
            above_ptr[i] = (32'(i) > 32'(ptr));
        end
    end

    assign req_masked = req & above_ptr;

    fixed_prio_encoder #(.N(N), .IDXW(IDXW)) u_masked (
        .vec   (req_masked),
        .found (found_masked),
        .idx   (idx_masked)
    );

    fixed_prio_encoder #(.N(N), .IDXW(IDXW)) u_fallback (
        .vec   (req),
        .found (found_any),
        .idx   (idx_any)
    );

    assign win_found = found_masked | found_any;
    assign win_idx   = found_masked ? idx_masked : idx_any;

    always_comb begin
        win_onehot = '0;
        if (win_found) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

    assign hold = (LOCK == ARB_MODE_LOCK) && gnt_valid && req[gnt_idx];

    // Output / pointer register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= IDXW'(N - 1);
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else if (!enable) begin
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else if (!hold) begin
            gnt       <= win_onehot;
            gnt_idx   <= win_found ? win_idx : '0;
            gnt_valid <= win_found;
            if (win_found) begin
                ptr <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: four instances (N=8/5, LOCK=0/1) checked
// every cycle against a search-order model, plus literal directed checks.
module tb_round_robin_arbiter;

    typedef struct packed {
        logic [2:0] ptr;
        logic [2:0] idx;
        logic       vld;
    } mst_t;

    logic       clk;
    logic       rst [4];
    logic       en  [4];
    logic [7:0] rq  [4];
    logic [7:0] g0, g1, g3;
    logic [7:0] g0w, g1w;
    logic [4:0] g2, g3w;
    logic [7:0] dg  [4];
    logic [2:0] di  [4];
    logic       dv  [4];
    mst_t       ms  [4];
    bit         chk_on;
    int         n_cmp;
    int         n_bad;

    logic [7:0] tv_req [10] = '{8'hFF, 8'h00, 8'hA5, 8'h3C, 8'h11,
                                8'h1F, 8'h80, 8'h42, 8'h06, 8'h1E};
    bit         tv_en  [10] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1};

    round_robin_arbiter #(.N(8), .IDXW(3), .LOCK(0)) u0 (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .req(rq[0]),
        .gnt(g0w), .gnt_idx(di[0]), .gnt_valid(dv[0]));
    round_robin_arbiter #(.N(8), .IDXW(3), .LOCK(1)) u1 (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .req(rq[1]),
        .gnt(g1w), .gnt_idx(di[1]), .gnt_valid(dv[1]));
    round_robin_arbiter #(.N(5), .IDXW(3), .LOCK(0)) u2 (
        .clk(clk), .reset(rst[2]), .enable(en[2]), .req(rq[2][4:0]),
        .gnt(g2), .gnt_idx(di[2]), .gnt_valid(dv[2]));
    round_robin_arbiter #(.N(5), .IDXW(3), .LOCK(1)) u3 (
        .clk(clk), .reset(rst[3]), .enable(en[3]), .req(rq[3][4:0]),
        .gnt(g3w), .gnt_idx(di[3]), .gnt_valid(dv[3]));

    assign g0    = g0w;
    assign g1    = g1w;
    assign g3    = {3'b000, g3w};
    assign dg[0] = g0;
    assign dg[1] = g1;
    assign dg[2] = {3'b000, g2};
    assign dg[3] = g3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: walk ptr+1, ptr+2, ... ptr (mod n) and take the first requester.
    function automatic mst_t step(input int n, input bit lock, input mst_t s,
                                  input logic [7:0] r, input logic e, input logic rs);
        mst_t o;
        o = s;
        if (rs) begin
            o.ptr = 3'(n - 1);
            o.idx = 3'd0;
            o.vld = 1'b0;
        end else if (!e) begin
            o.idx = 3'd0;
            o.vld = 1'b0;
        end else if (!(lock && s.vld && r[s.idx])) begin
            o.idx = 3'd0;
            o.vld = 1'b0;
            for (int k = 1; k <= n; k++) begin
                int c;
                c = (int'(s.ptr) + k) % n;
                if (!o.vld && r[3'(c)]) begin
                    o.vld = 1'b1;
                    o.idx = 3'(c);
                    o.ptr = 3'(c);
                end
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] egnt(input mst_t s);
        return s.vld ? (8'd1 << s.idx) : 8'h00;
    endfunction

    task automatic check(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[u%0d] t=%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Literal expectation for one instance: index and valid given by hand.
    task automatic lit(input string nm, input int k, input int idx, input bit vld);
        logic [7:0] eg;
        eg = vld ? (8'd1 << idx) : 8'h00;
        check({nm, ".gnt"}, k, dg[k], eg);
        check({nm, ".idx"}, k, {5'b0, di[k]}, 8'(idx));
        check({nm, ".vld"}, k, {7'b0, dv[k]}, {7'b0, vld});
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            ms[k] <= step((k < 2) ? 8 : 5, (k % 2) == 1, ms[k], rq[k], en[k], rst[k]);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 4; k++) begin
                check("model.gnt", k, dg[k], egnt(ms[k]));
                check("model.idx", k, {5'b0, di[k]}, {5'b0, ms[k].idx});
                check("model.vld", k, {7'b0, dv[k]}, {7'b0, ms[k].vld});
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        chk_on = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1;
            en[k]  = 1'b1;
            rq[k]  = 8'h00;
        end
        tick;
        tick;
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;
        chk_on = 1'b1;
        for (int k = 0; k < 4; k++) lit("reset", k, 0, 1'b0);

        // Two requesters at the extremes alternate.
        rq[0] = 8'b1000_0001;
        tick; lit("alt0", 0, 0, 1'b1);
        tick; lit("alt1", 0, 7, 1'b1);
        tick; lit("alt2", 0, 0, 1'b1);
        tick; lit("alt3", 0, 7, 1'b1);

        // Sole requester equal to ptr is re-granted, then full rotation.
        rq[0] = 8'h80;
        for (int j = 0; j < 3; j++) begin
            tick; lit("sole7", 0, 7, 1'b1);
        end
        rq[0] = 8'hFF;
        for (int j = 0; j < 9; j++) begin
            tick; lit("rot", 0, j % 8, 1'b1);
        end

        // Enable gap freezes ptr at 3; resume picks 4 out of {3,4}.
        rq[0] = 8'h08;
        tick; lit("g3", 0, 3, 1'b1);
        en[0] = 1'b0;
        tick; lit("en_off", 0, 0, 1'b0);
        en[0] = 1'b1;
        rq[0] = 8'h18;
        tick; lit("en_on", 0, 4, 1'b1);
        rq[0] = 8'h00;
        tick; lit("idle", 0, 0, 1'b0);

        // Lock: requester 0 holds despite req[2]; drop hands over with no gap.
        rq[1] = 8'h05;
        tick; lit("lk0", 1, 0, 1'b1);
        for (int j = 0; j < 5; j++) begin
            tick; lit("lkhold", 1, 0, 1'b1);
        end
        rq[1] = 8'h04;
        tick; lit("lk2", 1, 2, 1'b1);
        rq[1] = 8'h14;
        tick; lit("lk2hold", 1, 2, 1'b1);
        rst[1] = 1'b1;
        tick; lit("lkrst", 1, 0, 1'b0);
        rst[1] = 1'b0;
        tick; lit("lkpost", 1, 2, 1'b1);
        rq[1] = 8'h00;

        // N=5 wrap-around between indices 0 and 4.
        rq[2] = 8'b0001_0001;
        tick; lit("n5a", 2, 0, 1'b1);
        tick; lit("n5b", 2, 4, 1'b1);
        tick; lit("n5c", 2, 0, 1'b1);
        rq[2] = 8'h00;

        // N=5 locked hold, then reset drops it.
        rq[3] = 8'b0000_0100;
        tick; lit("n5lk", 3, 2, 1'b1);
        rq[3] = 8'b0000_0101;
        tick; lit("n5hold", 3, 2, 1'b1);
        rst[3] = 1'b1;
        tick; lit("n5rst", 3, 0, 1'b0);
        rst[3] = 1'b0;

        // Shared vector table across all instances, checked by the model.
        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < 4; k++) begin
                rq[k] = (k < 2) ? tv_req[t] : (tv_req[t] & 8'h1F);
                en[k] = tv_en[t];
            end
            repeat (3) tick;
        end
        for (int k = 0; k < 4; k++) rq[k] = 8'h00;
        tick;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
